// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor type and scheduler state encoding
package elevator_pkg;

    localparam int FLOOR_W = 4;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/nearest_call_finder.sv
// rtl/nearest_call_finder.sv - nearest pending call above/below/at the car
module nearest_call_finder #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic                  above_any,
    output logic [FLOOR_W-1:0]    above_idx,
    output logic                  below_any,
    output logic [FLOOR_W-1:0]    below_idx,
    output logic                  here
);

    // Descending scan for above and ascending for below: the last hit is the closest floor.
    always_comb begin
        above_any = 1'b0;
        above_idx = '0;
        below_any = 1'b0;
        below_idx = '0;
        here      = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(car_floor))) begin
                above_any = 1'b1;
                above_idx = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(car_floor))) begin
                below_any = 1'b1;
                below_idx = FLOOR_W'(i);
            end
            if (i == int'(car_floor)) begin
                here = pending[i];
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - pending-call bitmap and SCAN target selection
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  err_call
);

    import elevator_pkg::state_t;
    import elevator_pkg::IDLE;
    import elevator_pkg::UP;
    import elevator_pkg::DOWN;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] call_hot, clear_hot, pending_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  call_oor;
    logic [FLOOR_W-1:0]    target_nxt;
    logic                  valid_nxt;

    logic                  above_any, below_any, here;
    logic [FLOOR_W-1:0]    above_idx, below_idx;
    logic [FLOOR_W-1:0]    dist_up, dist_down;

    // One-hot decodes; an out-of-range floor simply decodes to all zeros.
    always_comb begin
        call_hot  = '0;
        clear_hot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            call_hot[i]  = call_valid && (call_floor == FLOOR_W'(i));
            clear_hot[i] = door_open && (car_floor == FLOOR_W'(i));
        end
    end

    assign call_oor = call_valid && (call_hot == '0);

    always_comb begin
        pending_nxt = enable ? ((pending | call_hot) & ~clear_hot) : '0;
        count_nxt   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            count_nxt = count_nxt + CNT_W'(pending_nxt[i]);
        end
    end

    nearest_call_finder #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_finder (
        .pending   (pending),
        .car_floor (car_floor),
        .above_any (above_any),
        .above_idx (above_idx),
        .below_any (below_any),
        .below_idx (below_idx),
        .here      (here)
    );

    assign dist_up   = above_idx - car_floor;
    assign dist_down = car_floor - below_idx;

    always_comb begin
        state_nxt  = state;
        target_nxt = target_floor;
        valid_nxt  = target_valid;
        if (!enable) begin
            state_nxt  = IDLE;
            target_nxt = car_floor;
            valid_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_nxt = 1'b1;
                    if (above_any && (!below_any || (dist_up <= dist_down))) begin
                        state_nxt  = UP;
                        target_nxt = above_idx;
                    end else if (below_any) begin
                        state_nxt  = DOWN;
                        target_nxt = below_idx;
                    end else if (here) begin
                        target_nxt = car_floor;
                    end else begin
                        valid_nxt = 1'b0;
                    end
                end
                UP: begin
                    valid_nxt = 1'b1;
                    if (above_any) begin
                        target_nxt = above_idx;
                    end else if (here) begin
                        target_nxt = car_floor;
                    end else if (below_any) begin
                        state_nxt  = DOWN;
                        target_nxt = below_idx;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
                DOWN: begin
                    valid_nxt = 1'b1;
                    if (below_any) begin
                        target_nxt = below_idx;
                    end else if (here) begin
                        target_nxt = car_floor;
                    end else if (above_any) begin
                        state_nxt  = UP;
                        target_nxt = above_idx;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= '0;
            pending_count <= '0;
            target_floor  <= '0;
            target_valid  <= 1'b0;
            err_call      <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            pending_count <= count_nxt;
            target_floor  <= target_nxt;
            target_valid  <= valid_nxt;
            err_call      <= enable && call_oor;
        end
    end

    assign dir_up   = (state == UP);
    assign dir_down = (state == DOWN);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - self-checking bench for elevator_call_scheduler
module tb_elevator_call_scheduler;

    localparam int NF = 12;
    localparam int FW = 4;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          call_valid;
    logic [FW-1:0] call_floor;
    logic [FW-1:0] car_floor;
    logic          door_open;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic          dir_up;
    logic          dir_down;
    logic [NF-1:0] pending;
    logic [CW-1:0] pending_count;
    logic          err_call;

    elevator_call_scheduler #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .car_floor     (car_floor),
        .door_open     (door_open),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .dir_up        (dir_up),
        .dir_down      (dir_down),
        .pending       (pending),
        .pending_count (pending_count),
        .err_call      (err_call)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] car;
        int            call_a;
        int            call_b;
        logic [NF-1:0] exp_pending;
        logic [FW-1:0] exp_target;
        logic          exp_valid;
        logic          exp_up;
        logic          exp_down;
    } vec_t;

    typedef struct {
        logic [NF-1:0] pend;
        logic [CW-1:0] cnt;
        logic [FW-1:0] target;
        logic          valid;
        logic          up;
        logic          down;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        call_valid = 1'b0;
        call_floor = '0;
        door_open  = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic call(input int f);
        call_valid = 1'b1;
        call_floor = 4'(f);
        tick();
        call_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pending"}, 32'(pending), 32'h0);
        check({tag, "_count"}, 32'(pending_count), 32'h0);
        check({tag, "_target"}, 32'(target_floor), 32'h0);
        check({tag, "_valid"}, 32'(target_valid), 32'h0);
        check({tag, "_up"}, 32'(dir_up), 32'h0);
        check({tag, "_down"}, 32'(dir_down), 32'h0);
        check({tag, "_err"}, 32'(err_call), 32'h0);
    endtask

    initial begin
        exp_t e;
        reset_n    = 1'b0;
        enable     = 1'b0;
        call_valid = 1'b0;
        call_floor = '0;
        car_floor  = '0;
        door_open  = 1'b0;

        // car, first call, second call (-1 none), pending, target, valid, up, down
        vecs[0] = '{4'd0,  5, -1, 12'h020, 4'd5,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{4'd9,  2, -1, 12'h004, 4'd2,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'd4,  4, -1, 12'h010, 4'd4,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'd3,  7,  1, 12'h082, 4'd7,  1'b1, 1'b1, 1'b0};
        vecs[4] = '{4'd6,  2, 11, 12'h804, 4'd2,  1'b1, 1'b0, 1'b1};
        vecs[5] = '{4'd0, 11,  3, 12'h808, 4'd3,  1'b1, 1'b1, 1'b0};
        vecs[6] = '{4'd11, 0,  8, 12'h101, 4'd8,  1'b1, 1'b0, 1'b1};
        vecs[7] = '{4'd5,  5,  9, 12'h220, 4'd9,  1'b1, 1'b1, 1'b0};
        vecs[8] = '{4'd3, 13, -1, 12'h000, 4'd0,  1'b0, 1'b0, 1'b0};

        tick();
        tick();
        check_all_zero("reset");

        for (int r = 0; r < 9; r++) begin
            do_reset();
            car_floor = vecs[r].car;
            enable    = 1'b1;
            call(vecs[r].call_a);
            if (vecs[r].call_b >= 0) call(vecs[r].call_b);
            e.pend   = vecs[r].exp_pending;
            e.cnt    = CW'($countones(vecs[r].exp_pending));
            e.target = vecs[r].exp_target;
            e.valid  = vecs[r].exp_valid;
            e.up     = vecs[r].exp_up;
            e.down   = vecs[r].exp_down;
            sb.push_back(e);
            tick();
            tick();
            tick();
            e = sb.pop_front();
            check($sformatf("vec%0d_pending", r), 32'(pending), 32'(e.pend));
            check($sformatf("vec%0d_count", r), 32'(pending_count), 32'(e.cnt));
            check($sformatf("vec%0d_target", r), 32'(target_floor), 32'(e.target));
            check($sformatf("vec%0d_valid", r), 32'(target_valid), 32'(e.valid));
            check($sformatf("vec%0d_up", r), 32'(dir_up), 32'(e.up));
            check($sformatf("vec%0d_down", r), 32'(dir_down), 32'(e.down));
        end

        // Single call latency: pending after N+1, target after N+2
        do_reset();
        car_floor = 4'd0;
        enable    = 1'b1;
        call(5);
        check("lat_pending_n1", 32'(pending), 32'h020);
        check("lat_count_n1", 32'(pending_count), 32'h1);
        check("lat_valid_n1", 32'(target_valid), 32'h0);
        tick();
        check("lat_target_n2", 32'(target_floor), 32'h5);
        check("lat_valid_n2", 32'(target_valid), 32'h1);
        check("lat_up_n2", 32'(dir_up), 32'h1);

        // Direction change after serving the top call
        do_reset();
        car_floor = 4'd5;
        enable    = 1'b1;
        call(7);
        call(3);
        tick();
        check("dir_target7", 32'(target_floor), 32'h7);
        check("dir_up_before", 32'(dir_up), 32'h1);
        car_floor = 4'd7;
        tick();
        door_open = 1'b1;
        tick();
        door_open = 1'b0;
        check("dir_pending_after_door", 32'(pending), 32'h008);
        tick();
        check("dir_target3", 32'(target_floor), 32'h3);
        check("dir_down_after", 32'(dir_down), 32'h1);
        check("dir_up_after", 32'(dir_up), 32'h0);

        // Equidistant calls from IDLE resolve upward
        do_reset();
        car_floor = 4'd6;
        enable    = 1'b1;
        call(6);
        call(10);
        check("tie_idle", 32'({dir_up, dir_down}), 32'h0);
        car_floor = 4'd8;
        tick();
        check("tie_pending", 32'(pending), 32'h440);
        check("tie_target", 32'(target_floor), 32'hA);
        check("tie_up", 32'(dir_up), 32'h1);

        // Same-cycle set and clear: clear wins
        do_reset();
        car_floor = 4'd4;
        enable    = 1'b1;
        door_open = 1'b1;
        call(4);
        door_open = 1'b0;
        check("clr_wins_pending", 32'(pending), 32'h0);
        check("clr_wins_count", 32'(pending_count), 32'h0);
        tick();
        check("clr_wins_valid", 32'(target_valid), 32'h0);

        // Out-of-range call
        do_reset();
        car_floor = 4'd0;
        enable    = 1'b1;
        call(2);
        check("oor_err_idle", 32'(err_call), 32'h0);
        call(13);
        check("oor_err_pulse", 32'(err_call), 32'h1);
        check("oor_pending", 32'(pending), 32'h004);
        tick();
        check("oor_err_clear", 32'(err_call), 32'h0);
        check("oor_count", 32'(pending_count), 32'h1);

        // Disable mid-sweep
        do_reset();
        car_floor = 4'd5;
        enable    = 1'b1;
        call(9);
        call(2);
        tick();
        check("dis_target9", 32'(target_floor), 32'h9);
        check("dis_up", 32'(dir_up), 32'h1);
        enable = 1'b0;
        tick();
        check("dis_pending", 32'(pending), 32'h0);
        check("dis_count", 32'(pending_count), 32'h0);
        check("dis_valid", 32'(target_valid), 32'h0);
        check("dis_target_car", 32'(target_floor), 32'h5);
        check("dis_dirs", 32'({dir_up, dir_down}), 32'h0);
        call(3);
        check("dis_call_ignored", 32'(pending), 32'h0);

        // Asynchronous reset with three calls pending
        do_reset();
        car_floor = 4'd1;
        enable    = 1'b1;
        call(4);
        call(8);
        call(10);
        tick();
        check("rst_pending_before", 32'(pending), 32'h510);
        check("rst_count_before", 32'(pending_count), 32'h3);
        check("rst_target_before", 32'(target_floor), 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("rst_valid_after", 32'(target_valid), 32'h0);
        check("rst_pending_after", 32'(pending), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

- Collects floor call requests (hall and car buttons) into a pending-call bitmap.
- Runs a collective up/down (SCAN) policy and presents one registered target floor at a time to the elevator motion controller.
- Sits upstream of that controller: it drives the controller's `target_floor` and `on` inputs, and consumes the controller's current-floor and door-open outputs to retire served calls.

## Interface

Parameters:
- `NUM_FLOORS`, default 16: number of serviced floors, 2..16; floors are 0..NUM_FLOORS-1.
- `FLOOR_W`, default 4: floor index width.
- `CNT_W`, default 5: width of `pending_count`, equal to $clog2(NUM_FLOORS+1).

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: scheduler enable; also forwarded to the controller as `on`.
- `call_valid` in 1: one-cycle call strobe; at most one call per cycle.
- `call_floor` in FLOOR_W: floor requested with `call_valid`.
- `car_floor` in FLOOR_W: current floor reported by the controller.
- `door_open` in 1: controller door-open indication; the call at `car_floor` is served.
- `target_floor` out FLOOR_W: registered floor the car must go to.
- `target_valid` out 1: `target_floor` is meaningful.
- `dir_up` out 1: scheduler is sweeping up.
- `dir_down` out 1: scheduler is sweeping down.
- `pending` out NUM_FLOORS: registered call bitmap.
- `pending_count` out CNT_W: registered popcount of `pending`.
- `err_call` out 1: one-cycle pulse on an out-of-range call.

## Operation

Reset values: `pending`=0, `pending_count`=0, state IDLE, `target_floor`=0, `target_valid`=0, `dir_up`=0, `dir_down`=0, `err_call`=0. Reset mid-operation discards all calls immediately.

Bitmap update, at each edge with `enable`=1:
- Set `pending[call_floor]` when `call_valid` is high and `call_floor` < NUM_FLOORS.
- Clear `pending[car_floor]` when `door_open` is high.
- If a set and a clear hit the same floor in the same cycle, clear wins: the call is already served.
- A call with `call_floor` >= NUM_FLOORS is dropped; `err_call` pulses 1 on the next edge.
- A repeated call for an already-pending floor has no effect.

Search terms, computed from the registered `pending` and the current `car_floor`:
- `above`: lowest set index greater than `car_floor`.
- `below`: highest set index less than `car_floor`.
- `here`: `pending[car_floor]`.

FSM states: IDLE, UP, DOWN. Next target and direction are evaluated every cycle and registered.

- **IDLE:**
  - `above` and `below` both exist: go to the nearer one. An equal distance goes UP.
  - Only `above` exists: go to UP with target `above`.
  - Only `below` exists: go to DOWN with target `below`.
  - Only `here` is set: stay IDLE, target `car_floor`, valid.
  - Nothing pending: `target_valid`=0 and `target_floor` holds its value.
- **UP:**
  - `above` exists: target `above`.
  - Else `here` is set: target `car_floor`.
  - Else `below` exists: go to DOWN with target `below`.
  - Else: go to IDLE, `target_valid`=0.
- **DOWN:** mirror image of UP.
- **Outputs:** `dir_up`=1 only in UP and `dir_down`=1 only in DOWN; the two are never both 1.
- **Disable:** `enable`=0 at any time clears `pending` and `pending_count`, forces IDLE, and sets `target_valid`=0 and `target_floor`=`car_floor` at the next edge. Calls are ignored while `enable`=0.

## Timing

- Call latency:
  - A call strobed in cycle N appears in `pending` and `pending_count` after edge N+1.
  - The resulting `target_floor` and `target_valid` update after edge N+2.
- Retire latency:
  - `door_open` sampled at edge M clears the bit at M.
  - The new target is presented at M+1.
- The target is stable between updates, with no combinational path from inputs to outputs.
- `pending_count` always equals the popcount of `pending` in the same cycle.

## Structure

- **Package `elevator_pkg`:**
  - FSM state encoding (IDLE, UP, DOWN).
  - `FLOOR_W` constant.
  - `floor_t` typedef.
  - Shared with the motion controller.
- **Sub-module `nearest_call_finder`:**
  - Combinational.
  - Inputs: `pending` mask and `car_floor`.
  - Outputs: `above_any`, `above_idx`, `below_any`, `below_idx`, `here`.
- **Top level:** holds the bitmap, the FSM, the target registers and the popcount.

## Test plan

- **Reset:** assert `reset_n`=0 mid-sweep with 3 calls pending → all outputs 0 immediately; after release, `target_valid` stays 0.
- **Single call:** car 0, IDLE, call floor 5 at cycle N → `pending`=0x0020 after N+1; `target_floor`=5, `target_valid`=1, `dir_up`=1 after N+2.
- **Direction change:**
  - UP, car 5, `pending`={7,3} → target 7.
  - `door_open` at car 7 → bit 7 cleared; next edge gives DOWN, target 3, `dir_down`=1.
- **Tie-break:** IDLE, car 8, `pending`={6,10} loaded together → UP, target 10.
- **Boundaries:**
  - `door_open` at car 4 with `call_valid`, floor 4, same cycle → bit 4 stays 0.
  - With NUM_FLOORS=12, call floor 13 → `err_call` pulses once and `pending` is unchanged.
- **Disable:** UP with target 9, `pending`={9,2}, drive `enable`=0 → next edge `pending`=0, `pending_count`=0, `target_valid`=0, `target_floor`=`car_floor`, state IDLE.
